// File: rtl/ff_check_pkg.sv
// ff_check_pkg
// Shared definitions for the flip-flop response checker: default field
// widths and the checker FSM state encoding.
package ff_check_pkg;

    localparam int LEN_W_DEF = 16;  // compare-length / sample-index width
    localparam int CNT_W_DEF = 8;   // saturating error counter width

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/ff_response_checker_if.sv
// ff_response_checker_if
// Bundles the checker's control, stimulus/response and result signals.
//   master : test controller side (drives start/len/d_stim/q_resp)
//   slave  : checker side (drives busy/done/pass/err_count/first_err_idx/state)
//
// Handshake: start is a one-cycle request, accepted only while the checker
// is in IDLE or DONE (busy low); len is sampled on the accepting edge.
// Results (done/pass/err_count/first_err_idx) are valid while done is high
// and hold until the next accepted start. state is a debug view of the FSM.
interface ff_response_checker_if
    import ff_check_pkg::*;
#(
    parameter int LEN_W = LEN_W_DEF,
    parameter int CNT_W = CNT_W_DEF
);
    logic             start;
    logic [LEN_W-1:0] len;
    logic             d_stim;
    logic             q_resp;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] err_count;
    logic [LEN_W-1:0] first_err_idx;
    state_t           state;

    modport master (
        output start, len, d_stim, q_resp,
        input  busy, done, pass, err_count, first_err_idx, state
    );

    modport slave (
        input  start, len, d_stim, q_resp,
        output busy, done, pass, err_count, first_err_idx, state
    );
endinterface

// File: rtl/ff_sat_counter.sv
// ff_sat_counter
// Up-counter that sticks at all-ones.
//   clk, rst : clock, asynchronous active-high reset (count -> 0)
//   clear    : synchronous clear, wins over inc
//   inc      : count up by one unless saturated
//   count    : current value
//   sat      : high when count is all-ones
module ff_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         sat
);
    assign sat = &count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && !sat) begin
            count <= count + W'(1);
        end
    end
endmodule

// File: rtl/ff_response_checker.sv
// ff_response_checker
// Checks a flip-flop under test: each cycle in RUN, q_resp is compared with
// the d_stim value captured on the previous cycle. Counts mismatches
// (saturating) and records the index of the first one.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : ff_response_checker_if.slave
//              in : start, len, d_stim, q_resp
//              out: busy (ARM/RUN), done (DONE), pass (DONE && no errors),
//                   err_count, first_err_idx (all-ones if none), state (debug)
// All outputs come from registers or the state register only; q_resp and
// d_stim never reach an output combinationally.
module ff_response_checker
    import ff_check_pkg::*;
#(
    parameter int LEN_W = LEN_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    ff_response_checker_if.slave  bus
);
    localparam logic [LEN_W-1:0] IDX_ONE  = LEN_W'(1);
    localparam logic [LEN_W-1:0] NO_ERROR = '1;

    state_t           state, state_nxt;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] idx;
    logic [LEN_W-1:0] first_q;
    logic             exp_q;
    logic [CNT_W-1:0] err_cnt;
    logic             err_sat;

    logic accept;
    logic mismatch;
    logic last_cmp;

    assign accept   = ((state == ST_IDLE) || (state == ST_DONE)) && bus.start;
    assign mismatch = (state == ST_RUN) && (bus.q_resp != exp_q);
    // The compare of index len-1 is the last one of the run.
    assign last_cmp = (idx == (len_q - IDX_ONE));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    // A zero-length run has nothing to compare: finish at once.
                    state_nxt = (bus.len == '0) ? ST_DONE : ST_ARM;
                end
            end
            ST_ARM:  state_nxt = ST_RUN;
            ST_RUN:  if (last_cmp) state_nxt = ST_DONE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: expected value pipeline, sample index, first-error capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q   <= '0;
            idx     <= '0;
            exp_q   <= 1'b0;
            first_q <= NO_ERROR;
        end else if (accept) begin
            len_q   <= bus.len;
            idx     <= '0;
            first_q <= NO_ERROR;
        end else if (state == ST_ARM) begin
            exp_q <= bus.d_stim;
        end else if (state == ST_RUN) begin
            exp_q <= bus.d_stim;
            // idx stops at len-1 <= 2**LEN_W-2, so this never wraps.
            idx   <= idx + IDX_ONE;
            // All-ones doubles as "no error yet": a compared index never
            // reaches all-ones, so the sentinel is unambiguous.
            if (mismatch && (first_q == NO_ERROR)) begin
                first_q <= idx;
            end
        end
    end

    ff_sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (accept),
        .inc   (mismatch && !err_sat),
        .count (err_cnt),
        .sat   (err_sat)
    );

    assign bus.busy          = (state == ST_ARM) || (state == ST_RUN);
    assign bus.done          = (state == ST_DONE);
    assign bus.pass          = (state == ST_DONE) && (err_cnt == '0);
    assign bus.err_count     = err_cnt;
    assign bus.first_err_idx = first_q;
    assign bus.state         = state;
endmodule

// File: tb/tb_ff_response_checker.sv
// tb_ff_response_checker
// Table-driven bench for ff_response_checker. An ideal D flip-flop model
// produces q_resp from a d_stim that toggles every cycle; inv forces q_resp
// inverted on chosen compare indices to create mismatches.
module tb_ff_response_checker;
    import ff_check_pkg::*;

    localparam int LW = 16;
    localparam int CW = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ff_response_checker_if #(.LEN_W(LW), .CNT_W(CW)) bus();

    ff_response_checker #(.LEN_W(LW), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- flip-flop under test model ----------------
    logic d_tgl = 1'b0;
    logic dff_q = 1'b0;
    logic inv   = 1'b0;

    always @(negedge clk) d_tgl <= ~d_tgl;
    always @(posedge clk) dff_q <= d_tgl;
    assign bus.d_stim = d_tgl;
    assign bus.q_resp = dff_q ^ inv;

    // ---------------- scoreboard ----------------
    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic bit fault_at(input int mode, input int k);
        case (mode)
            1:       return (k == 3) || (k == 7);
            2:       return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // ---------------- driver ----------------
    // Accepts start at edge T0; the compare of index k happens at edge
    // T(k+2), so inv for index k is applied in the cycle before it.
    // stray >= 0 pulses start (len=2) in that cycle to prove it is ignored.
    task automatic run_vec(input int len, input int mode, input int stray,
                           output int lat);
        @(negedge clk);
        bus.start = 1'b1;
        bus.len   = 16'(len);
        @(posedge clk);
        lat = -1;
        for (int j = 0; j < len + 20; j++) begin
            @(negedge clk);
            if (bus.done) begin
                lat = j;
                break;
            end
            bus.start = (j == stray);
            bus.len   = 16'd2;
            inv       = (j >= 1) && fault_at(mode, j - 1);
        end
        bus.start = 1'b0;
        inv       = 1'b0;
    endtask

    typedef struct {
        string name;
        int    len;
        int    mode;
        int    stray;
        int    exp_lat;
        int    exp_err;
        int    exp_first;
        int    exp_pass;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;

        vecs[0] = '{"clean",        10,  0, -1, 11,  0,     65535, 1};
        vecs[1] = '{"fault_3_7",    10,  1, -1, 11,  2,     3,     0};
        vecs[2] = '{"restart_len4", 4,   0, -1, 5,   0,     65535, 1};
        vecs[3] = '{"saturate",     300, 2, -1, 301, 255,   0,     0};
        vecs[4] = '{"ignore_start", 10,  2, 4,  11,  10,    0,     0};
        vecs[5] = '{"len1_err",     1,   2, -1, 2,   1,     0,     0};
        vecs[6] = '{"len1_clean",   1,   0, -1, 2,   0,     65535, 1};

        // ---- reset state ----
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.len   = '0;
        #1;
        check("rst_busy",  int'(bus.busy), 0);
        check("rst_done",  int'(bus.done), 0);
        check("rst_pass",  int'(bus.pass), 0);
        check("rst_err",   int'(bus.err_count), 0);
        check("rst_first", int'(bus.first_err_idx), 65535);
        check("rst_state", int'(bus.state), int'(ST_IDLE));
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("no_autostart_busy", int'(bus.busy), 0);
        check("no_autostart_done", int'(bus.done), 0);

        // ---- len = 0: DONE next cycle, busy never high ----
        @(negedge clk);
        bus.start = 1'b1;
        bus.len   = '0;
        check("len0_busy_pre", int'(bus.busy), 0);
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        check("len0_busy",  int'(bus.busy), 0);
        check("len0_done",  int'(bus.done), 1);
        check("len0_pass",  int'(bus.pass), 1);
        check("len0_err",   int'(bus.err_count), 0);
        check("len0_first", int'(bus.first_err_idx), 65535);

        // ---- table vectors ----
        for (int v = 0; v < 7; v++) begin
            run_vec(vecs[v].len, vecs[v].mode, vecs[v].stray, lat);
            check({vecs[v].name, "_latency"}, lat, vecs[v].exp_lat);
            check({vecs[v].name, "_err"},   int'(bus.err_count), vecs[v].exp_err);
            check({vecs[v].name, "_first"}, int'(bus.first_err_idx), vecs[v].exp_first);
            check({vecs[v].name, "_pass"},  int'(bus.pass), vecs[v].exp_pass);
            check({vecs[v].name, "_busy"},  int'(bus.busy), 0);
            // Results must hold while idle in DONE.
            repeat (3) @(negedge clk);
            check({vecs[v].name, "_hold_done"}, int'(bus.done), 1);
            check({vecs[v].name, "_hold_err"},  int'(bus.err_count), vecs[v].exp_err);
            check({vecs[v].name, "_hold_pass"}, int'(bus.pass), vecs[v].exp_pass);
        end

        // ---- reset at index 5 of a len=10 run ----
        @(negedge clk);
        bus.start = 1'b1;
        bus.len   = 16'd10;
        @(posedge clk);
        for (int j = 0; j < 7; j++) begin
            @(negedge clk);
            bus.start = 1'b0;
            inv       = (j >= 1);
        end
        @(negedge clk);  // indices 0..5 compared, all mismatching
        check("midrun_busy", int'(bus.busy), 1);
        check("midrun_err",  int'(bus.err_count), 6);
        rst = 1'b1;
        #1;
        check("abort_busy",  int'(bus.busy), 0);
        check("abort_done",  int'(bus.done), 0);
        check("abort_pass",  int'(bus.pass), 0);
        check("abort_err",   int'(bus.err_count), 0);
        check("abort_first", int'(bus.first_err_idx), 65535);
        check("abort_state", int'(bus.state), int'(ST_IDLE));
        inv = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("post_abort_busy", int'(bus.busy), 0);
        check("post_abort_done", int'(bus.done), 0);
        check("post_abort_err",  int'(bus.err_count), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/ff_response_checker.md
FF_RESPONSE_CHECKER -- requirements
Module: ff_response_checker

Interface
REQ-001 SHALL have parameter LEN_W, default 16, width of compare-length and index fields.
REQ-002 SHALL have parameter CNT_W, default 8, width of the saturating error counter.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a check run.
REQ-006 SHALL have port len  input  LEN_W  number of Q samples to compare; sampled on accepted start.
REQ-007 SHALL have port d_stim  input  1  D value currently driven into the flip-flop under test.
REQ-008 SHALL have port q_resp  input  1  Q output of the flip-flop under test.
REQ-009 SHALL have port busy  output  1  high in ARM and RUN.
REQ-010 SHALL have port done  output  1  high in DONE.
REQ-011 SHALL have port pass  output  1  high in DONE when err_count is zero.
REQ-012 SHALL have port err_count  output  CNT_W  mismatch count, saturating at all-ones.
REQ-013 SHALL have port first_err_idx  output  LEN_W  sample index of first mismatch; all-ones if none.

Function
REQ-014 SHALL implement FSM states IDLE, ARM, RUN, DONE.
REQ-015 SHALL, in IDLE or DONE with start=1, latch len, clear err_count, set first_err_idx to all-ones, clear sample index, go to ARM.
REQ-016 SHALL, on accepted start with len=0, go directly to DONE with pass=1, err_count=0.
REQ-017 SHALL, in ARM, register exp <= d_stim and go to RUN next cycle.
REQ-018 SHALL, in RUN each cycle, compare q_resp against exp (d_stim of previous cycle), then load exp <= d_stim and increment index.
REQ-019 SHALL, on mismatch, increment err_count unless already all-ones.
REQ-020 SHALL, on the first mismatch of a run, record the current index into first_err_idx; later mismatches leave it unchanged.
REQ-021 SHALL leave RUN for DONE on the cycle in which index len-1 is compared; exactly len compares per run.
REQ-022 SHALL ignore start in ARM and RUN.
REQ-023 SHALL hold done, pass, err_count, first_err_idx stable in DONE until the next accepted start.
REQ-024 SHALL drive pass=0 outside DONE.
REQ-025 SHALL have latency: done rises len+1 cycles after the edge accepting start (len>0).
REQ-026 SHALL handle index count up to 2**LEN_W-1 with no wrap during a run.

Reset
REQ-027 SHALL, on rst=1, force state IDLE, busy=0, done=0, pass=0, err_count=0, first_err_idx=all-ones, exp=0, index=0, asynchronously.
REQ-028 SHALL abort any run when reset asserts mid-operation; no partial result retained.
REQ-029 SHALL require a new start after reset release; no auto-start.

Structure
REQ-030 SHALL place the state encoding and LEN_W/CNT_W defaults in shared package ff_check_pkg.
REQ-031 SHALL implement the saturating error counter as sub-module ff_sat_counter (clear, inc, saturate flag).
REQ-032 SHALL contain no combinational path from q_resp or d_stim to any output.

Verification
REQ-033 SHALL verify clean run: ideal D flip-flop as DUT, d_stim toggles every cycle, len=10 -> done after 11 cycles, pass=1, err_count=0, first_err_idx=16'hFFFF.
REQ-034 SHALL verify fault: q_resp forced inverted at index 3 and 7, len=10 -> err_count=2, first_err_idx=3, pass=0.
REQ-035 SHALL verify saturation: q_resp stuck inverted, len=300, CNT_W=8 -> err_count=255, first_err_idx=0.
REQ-036 SHALL verify len=0 start -> DONE next cycle, pass=1, busy never asserted.
REQ-037 SHALL verify reset at index 5 of a len=10 run -> all outputs at reset values immediately; start ignored during RUN produces no restart.
REQ-038 SHALL verify restart from DONE: second start with len=4 clears prior err_count=2 result and ends pass=1.
